// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with line-wide mem port and hit/miss counters.
// Optional DCACHE_FLUSH_EN adds flush_i/flush_done_o and a walk that writes back dirty lines.
module dcache #(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef DCACHE_FLUSH_EN
  input  logic                    flush_i,
  output logic                    flush_done_o,
`endif
  input  logic                    req_valid_i,
  input  logic                    req_we_i,
  input  logic                    req_size_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic                    mem_rd_req_o,
  output logic                    mem_wr_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_wr_data_o,
  input  logic                    mem_data_valid_i,
  input  logic [LINE_BYTES*8-1:0] mem_data_i,
  input  logic                    mem_wr_done_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int unsigned Off   = $clog2(LINE_BYTES);
  localparam int unsigned Idx   = $clog2(NUM_LINES);
  localparam int unsigned TagW  = ADDR_WIDTH - Off - Idx;
  localparam int unsigned LineW = LINE_BYTES * 8;

`ifdef DCACHE_FLUSH_EN
  typedef enum logic [2:0] {
    StIdle, StLookup, StWriteback, StRefill, StResp, StFlush, StFlushWb, StFlushDone
  } state_e;
  logic [Idx-1:0] flush_idx_q, flush_idx_d;
`else
  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StRefill, StResp} state_e;
`endif

  state_e                state_q, state_d;
  logic                  we_q, we_d, size_q, size_d, first_q, first_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [TagW-1:0]       tag_q  [NUM_LINES];
  logic [TagW-1:0]       tag_d  [NUM_LINES];
  logic [LineW-1:0]      data_q [NUM_LINES];
  logic [LineW-1:0]      data_d [NUM_LINES];

  logic [Idx-1:0]  idx;
  logic [TagW-1:0] tag;
  logic [Off-1:0]  boff;
  logic [Off-3:0]  word_sel;
  logic            hit;

  assign idx      = addr_q[Off+Idx-1:Off];
  assign tag      = addr_q[ADDR_WIDTH-1:Off+Idx];
  assign boff     = addr_q[Off-1:0];
  assign word_sel = addr_q[Off-1:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      rdata_q    <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rdata_q    <= rdata_d;
      first_q    <= first_d;
    end
  end

  // Request latch and line storage are not cleared by reset; only gated so a reset cycle is inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
`ifdef DCACHE_FLUSH_EN
      flush_idx_q <= flush_idx_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    first_d    = first_q;
    rdata_d    = rdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
`ifdef DCACHE_FLUSH_EN
    flush_idx_d = flush_idx_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef DCACHE_FLUSH_EN
        if (flush_i) begin
          flush_idx_d = '0;
          state_d     = StFlush;
        end else
`endif
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          first_d = 1'b1;
          state_d = StLookup;
        end
      end
      StLookup: begin
        first_d = 1'b0;
        if (hit) begin
          if (first_q) hit_cnt_d = hit_cnt_q + 32'd1;
          rdata_d = '0;
          if (we_q) begin
            if (size_q) data_d[idx][{word_sel, 5'b0} +: DATA_WIDTH] = wdata_q;
            else        data_d[idx][{boff, 3'b0} +: 8] = wdata_q[7:0];
            dirty_d[idx] = 1'b1;
          end else if (size_q) begin
            rdata_d = data_q[idx][{word_sel, 5'b0} +: DATA_WIDTH];
          end else begin
            rdata_d = {{(DATA_WIDTH-8){1'b0}}, data_q[idx][{boff, 3'b0} +: 8]};
          end
          state_d = StResp;
        end else begin
          if (first_q) miss_cnt_d = miss_cnt_q + 32'd1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StRefill;
        end
      end
      StWriteback: if (mem_wr_done_i) state_d = StRefill;
      StRefill: begin
        if (mem_data_valid_i) begin
          data_d[idx]  = mem_data_i;
          tag_d[idx]   = tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = StLookup;
        end
      end
      StResp: state_d = StIdle;
`ifdef DCACHE_FLUSH_EN
      StFlush: begin
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) state_d = StFlushWb;
        else if (flush_idx_q == Idx'(NUM_LINES - 1))      state_d = StFlushDone;
        else flush_idx_d = flush_idx_q + 1'b1;
      end
      StFlushWb: begin
        if (mem_wr_done_i) begin
          dirty_d[flush_idx_q] = 1'b0;
          if (flush_idx_q == Idx'(NUM_LINES - 1)) begin
            state_d = StFlushDone;
          end else begin
            flush_idx_d = flush_idx_q + 1'b1;
            state_d     = StFlush;
          end
        end
      end
      StFlushDone: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    resp_valid_o  = 1'b0;
    resp_rdata_o  = '0;
    mem_rd_req_o  = 1'b0;
    mem_wr_req_o  = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
`ifdef DCACHE_FLUSH_EN
    flush_done_o  = 1'b0;
`endif
    case (state_q)
      StWriteback: begin
        mem_wr_req_o  = 1'b1;
        mem_addr_o    = {tag_q[idx], idx, {Off{1'b0}}};
        mem_wr_data_o = data_q[idx];
      end
      StRefill: begin
        mem_rd_req_o = 1'b1;
        mem_addr_o   = {tag, idx, {Off{1'b0}}};
      end
      StResp: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
      end
`ifdef DCACHE_FLUSH_EN
      StFlushWb: begin
        mem_wr_req_o  = 1'b1;
        mem_addr_o    = {tag_q[flush_idx_q], flush_idx_q, {Off{1'b0}}};
        mem_wr_data_o = data_q[flush_idx_q];
      end
      StFlushDone: flush_done_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: stimulus pushes expected responses and mem requests,
// independent monitors pop and compare; a small line-wide memory model answers requests.
module tb_dcache;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid_i = 1'b0, req_we_i = 1'b0, req_size_i = 1'b0;
  logic [31:0]  req_addr_i = '0, req_wdata_i = '0;
  logic         resp_valid_o, mem_rd_req_o, mem_wr_req_o;
  logic [31:0]  resp_rdata_o, mem_addr_o, hit_cnt_o, miss_cnt_o;
  logic [127:0] mem_wr_data_o;
  logic         mem_data_valid_i = 1'b0, mem_wr_done_i = 1'b0;
  logic [127:0] mem_data_i = '0;
`ifdef DCACHE_FLUSH_EN
  logic         flush_i = 1'b0;
  logic         flush_done_o;
`endif

  always #5 clk = ~clk;

  dcache dut (
    .clk(clk), .rst(rst),
`ifdef DCACHE_FLUSH_EN
    .flush_i(flush_i), .flush_done_o(flush_done_o),
`endif
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_wr_req_o(mem_wr_req_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_data_valid_i(mem_data_valid_i),
    .mem_data_i(mem_data_i), .mem_wr_done_i(mem_wr_done_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] word0;
    logic        chk;
  } mem_exp_t;

  mem_exp_t     mem_q[$];
  logic [31:0]  resp_q[$];
  logic [127:0] mem [logic [31:0]];
  logic         mem_hold = 1'b0;
  int           checks = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic wr, input logic [31:0] addr, input logic [31:0] w0,
                         input logic c);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.word0 = w0; e.chk = c;
    mem_q.push_back(e);
  endtask

  // Memory model: answers a held request on its third negedge.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      mem_data_valid_i = 1'b0;
      mem_wr_done_i    = 1'b0;
      if (!rst || mem_hold || !(mem_rd_req_o || mem_wr_req_o)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          if (mem_wr_req_o) begin
            mem[mem_addr_o] = mem_wr_data_o;
            mem_wr_done_i   = 1'b1;
          end else begin
            mem_data_i       = mem[mem_addr_o];
            mem_data_valid_i = 1'b1;
          end
        end
      end
    end
  end

  initial begin : resp_monitor
    forever begin
      @(negedge clk);
      if (rst && resp_valid_o) begin
        if (resp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL resp_unexpected: got rdata 0x%08h expected no response", resp_rdata_o);
        end else begin
          chk("resp_rdata", resp_rdata_o, resp_q.pop_front());
        end
      end
    end
  end

  initial begin : mem_monitor
    logic prev_rd, prev_wr;
    mem_exp_t e;
    prev_rd = 1'b0; prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_req_o || mem_wr_req_o)
        chk("mem_one_req", {31'b0, mem_rd_req_o & mem_wr_req_o}, 32'd0);
      if ((mem_rd_req_o && !prev_rd) || (mem_wr_req_o && !prev_wr)) begin
        if (mem_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL mem_unexpected: got wr=%0b addr 0x%08h expected no request",
                   mem_wr_req_o, mem_addr_o);
        end else begin
          e = mem_q.pop_front();
          chk("mem_kind_wr", {31'b0, mem_wr_req_o}, {31'b0, e.wr});
          chk("mem_addr", mem_addr_o, e.addr);
          if (e.chk) chk("mem_wr_word0", mem_wr_data_o[31:0], e.word0);
        end
      end
      prev_rd = mem_rd_req_o;
      prev_wr = mem_wr_req_o;
    end
  end

  // Issues one request and returns the number of negedges until resp_valid_o.
  task automatic do_req(input logic we, input logic size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, output int lat);
    resp_q.push_back(exp);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_addr_i = addr; req_wdata_i = wdata;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (resp_valid_o) break;
      if (lat > 200) begin
        checks++; fails++;
        $display("FAIL resp_timeout: got no response for 0x%08h expected one", addr);
        break;
      end
    end
    req_valid_i = 1'b0;
  endtask

`ifdef DCACHE_FLUSH_EN
  task automatic do_flush(output int lat);
    @(negedge clk);
    flush_i = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) flush_i = 1'b0;
      if (flush_done_o) break;
      if (lat > 300) begin
        checks++; fails++;
        $display("FAIL flush_timeout: got no flush_done_o expected a pulse");
        break;
      end
    end
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int lat;
    mem[32'h1000] = {32'h0, 32'h55667788, 32'h11223344, 32'hDEADBEEF};
    mem[32'h1040] = {32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
    mem[32'h2000] = '0;
    mem[32'h3000] = {32'h0, 32'h0, 32'h0, 32'h0BADF00D};

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    chk("rst_rd_req", {31'b0, mem_rd_req_o}, 32'd0);
    chk("rst_wr_req", {31'b0, mem_wr_req_o}, 32'd0);
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);
    rst = 1'b1;

    exp_mem(1'b0, 32'h1000, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'h1000, 32'h0, 32'hDEADBEEF, lat);
    chk("t1_miss_cnt", miss_cnt_o, 32'd1);

    do_req(1'b0, 1'b1, 32'h1004, 32'h0, 32'h11223344, lat);
    chk("t2_hit_latency", lat, 32'd2);
    chk("t2_hit_cnt", hit_cnt_o, 32'd1);

    do_req(1'b1, 1'b0, 32'h1001, 32'h000000AB, 32'h0, lat);
    do_req(1'b0, 1'b1, 32'h1000, 32'h0, 32'hDEADABEF, lat);
    do_req(1'b0, 1'b0, 32'h1001, 32'h0, 32'h000000AB, lat);
    do_req(1'b0, 1'b1, 32'h1002, 32'h0, 32'hDEADABEF, lat);
    chk("t3_hit_cnt", hit_cnt_o, 32'd5);

    exp_mem(1'b1, 32'h1000, 32'hDEADABEF, 1'b1);
    exp_mem(1'b0, 32'h1040, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'h1040, 32'h0, 32'hCAFEF00D, lat);
    chk("t4_miss_cnt", miss_cnt_o, 32'd2);
    chk("t4_hit_cnt", hit_cnt_o, 32'd5);

`ifdef DCACHE_FLUSH_EN
    exp_mem(1'b0, 32'h2000, 32'h0, 1'b0);
    do_req(1'b1, 1'b1, 32'h2000, 32'h12345678, 32'h0, lat);
    exp_mem(1'b1, 32'h2000, 32'h12345678, 1'b1);
    do_flush(lat);
    do_flush(lat);
    chk("t5_clean_flush_latency", lat, 32'd5);
    do_req(1'b0, 1'b1, 32'h2000, 32'h0, 32'h12345678, lat);
    chk("t5_hit_after_flush", lat, 32'd2);
`endif

    mem_hold = 1'b1;
    exp_mem(1'b0, 32'h3000, 32'h0, 1'b0);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 1'b1; req_addr_i = 32'h3000;
    lat = 0;
    while (!mem_rd_req_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("t6_refill_started", {31'b0, mem_rd_req_o}, 32'd1);
    rst = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_rd_req_dropped", {31'b0, mem_rd_req_o}, 32'd0);
    chk("t6_miss_cnt_cleared", miss_cnt_o, 32'd0);
    rst = 1'b1;
    mem_hold = 1'b0;
    exp_mem(1'b0, 32'h3000, 32'h0, 1'b0);
    do_req(1'b0, 1'b1, 32'h3000, 32'h0, 32'h0BADF00D, lat);
    chk("t6_miss_cnt", miss_cnt_o, 32'd1);
    chk("t6_hit_cnt", hit_cnt_o, 32'd0);

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", resp_q.size(), 32'd0);
    chk("mem_queue_drained", mem_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
